exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer directly upstream of the CP0 register file.
//  - Watches the retiring instruction (syscall/break/teq/eret) and the external interrupt lines.
//  - Checks the CP0 status word.
//  - Issues the one-cycle exception/eret strobes, cause code and EPC value that CP0 consumes.
//  - Issues the PC redirect and pipeline stall to the fetch/control logic.
//  - Guarantees one CP0 update per event, plus a settle cycle before the next event is accepted.

---
 rtl/exc_ctrl_if.sv | 36 +++
 rtl/exc_ctrl.sv | 104 ++++++++++
 tb/tb_exc_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Handshake bundle between the retire stage, CP0 and the exception sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface exc_ctrl_if #(
   parameter int INT_W = 4
);
   logic             instr_valid;
   logic [31:0]      pc;
   logic             is_syscall;
   logic             is_break;
   logic             is_teq;
   logic             teq_eq;
   logic             is_eret;
   logic [INT_W-1:0] int_req;
   logic [31:0]      status;
   logic [31:0]      epc_in;
   logic             exception;
   logic             eret;
   logic [4:0]       cause;
   logic [31:0]      epc_out;
   logic             kill;
   logic             pc_redirect;
   logic [31:0]      redirect_addr;
   logic             stall;

   modport slave (
      input  instr_valid, pc, is_syscall, is_break, is_teq, teq_eq, is_eret,
             int_req, status, epc_in,
      output exception, eret, cause, epc_out, kill, pc_redirect, redirect_addr, stall
   );

   modport master (
      output instr_valid, pc, is_syscall, is_break, is_teq, teq_eq, is_eret,
             int_req, status, epc_in,
      input  exception, eret, cause, epc_out, kill, pc_redirect, redirect_addr, stall
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer feeding CP0: one strobe per event, then a settle
// cycle so the updated status word is visible before the next evaluation.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
   parameter int          INT_W      = 4
) (
   input logic         clk,
   input logic         rst,
   exc_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, EXC, RET, SETTLE} state_e;

   state_e           state_q, state_d;
   logic [INT_W-1:0] int_s1_q, int_s2_q;
   logic [4:0]       cause_q, cause_d;
   logic [31:0]      epc_q, epc_d;

   logic int_pend, take_sys, take_brk, take_teq, take_int, take_eret, take_exc;
   logic exception_o, eret_o, pc_redirect_o, stall_o, kill_o;
   logic [31:0] redirect_addr_o;
   logic unused_status;

   assign unused_status = ^bus.status[31:5];

   // Decode is only honoured in IDLE; every other state ignores the retire port.
   assign int_pend  = (|int_s2_q) & bus.status[0] & bus.status[4];
   assign take_sys  = bus.instr_valid & bus.is_syscall & bus.status[0] & bus.status[1];
   assign take_brk  = bus.instr_valid & bus.is_break & bus.status[0] & bus.status[2];
   assign take_teq  = bus.instr_valid & bus.is_teq & bus.teq_eq & bus.status[0] & bus.status[3];
   assign take_int  = bus.instr_valid & int_pend;
   assign take_eret = bus.instr_valid & bus.is_eret;
   assign take_exc  = take_sys | take_brk | take_teq | take_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         int_s1_q <= '0;
         int_s2_q <= '0;
         cause_q  <= '0;
         epc_q    <= '0;
      end else begin
         state_q  <= state_d;
         int_s1_q <= bus.int_req;
         int_s2_q <= int_s1_q;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      kill_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (take_exc) begin
               state_d = EXC;
               kill_o  = ~rst;
               epc_d   = bus.pc;
               if (take_sys)      cause_d = 5'd8;
               else if (take_brk) cause_d = 5'd9;
               else if (take_teq) cause_d = 5'd13;
               else               cause_d = 5'd0;
            end else if (take_eret) begin
               state_d = RET;
            end
         end
         EXC, RET: state_d = SETTLE;
         SETTLE:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      exception_o     = 1'b0;
      eret_o          = 1'b0;
      pc_redirect_o   = 1'b0;
      redirect_addr_o = '0;
      stall_o         = (state_q != IDLE);
      unique case (state_q)
         EXC: begin
            exception_o     = 1'b1;
            pc_redirect_o   = 1'b1;
            redirect_addr_o = EXC_VECTOR;
         end
         RET: begin
            eret_o          = 1'b1;
            pc_redirect_o   = 1'b1;
            redirect_addr_o = bus.epc_in;
         end
         default: ;
      endcase
   end

   assign bus.exception     = exception_o;
   assign bus.eret          = eret_o;
   assign bus.cause         = cause_q;
   assign bus.epc_out       = epc_q;
   assign bus.kill          = kill_o;
   assign bus.pc_redirect   = pc_redirect_o;
   assign bus.redirect_addr = redirect_addr_o;
   assign bus.stall         = stall_o;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: hand-computed expectations checked with immediate assertions.
module tb_exc_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   exc_ctrl_if #(.INT_W(4)) bus ();
   exc_ctrl #(.EXC_VECTOR(32'h0040_0004), .INT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.instr_valid = 0; bus.is_syscall = 0; bus.is_break = 0;
      bus.is_teq = 0; bus.teq_eq = 0; bus.is_eret = 0;
   endtask

   initial begin
      clr();
      bus.pc = 0; bus.int_req = 0; bus.status = 0; bus.epc_in = 0;
      tick(); tick();
      chk("rst_exc",   32'(bus.exception),   0);
      chk("rst_eret",  32'(bus.eret),        0);
      chk("rst_stall", 32'(bus.stall),       0);
      chk("rst_redir", 32'(bus.pc_redirect), 0);
      chk("rst_cause", 32'(bus.cause),       0);
      chk("rst_epc",   bus.epc_out,          0);
      chk("rst_kill",  32'(bus.kill),        0);
      rst = 0;

      // 1: syscall
      bus.status = 32'h3; bus.instr_valid = 1; bus.is_syscall = 1; bus.pc = 32'h0040_0100;
      #1 chk("t1_kill", 32'(bus.kill), 1);
      tick(); clr();
      chk("t1_exc",   32'(bus.exception), 1);
      chk("t1_cause", 32'(bus.cause), 8);
      chk("t1_epc",   bus.epc_out, 32'h0040_0100);
      chk("t1_raddr", bus.redirect_addr, 32'h0040_0004);
      chk("t1_pcr",   32'(bus.pc_redirect), 1);
      chk("t1_stall", 32'(bus.stall), 1);
      chk("t1_eret",  32'(bus.eret), 0);
      tick();
      chk("t1_set_exc",   32'(bus.exception), 0);
      chk("t1_set_stall", 32'(bus.stall), 1);
      chk("t1_set_cause", 32'(bus.cause), 8);
      tick();
      chk("t1_idle_stall", 32'(bus.stall), 0);

      // 2: teq / disabled break
      bus.status = 32'h9; bus.instr_valid = 1; bus.is_teq = 1; bus.teq_eq = 0; bus.pc = 32'h100;
      #1 chk("t2_neq_kill", 32'(bus.kill), 0);
      tick();
      chk("t2_neq_exc", 32'(bus.exception), 0);
      chk("t2_neq_stall", 32'(bus.stall), 0);
      bus.teq_eq = 1;
      #1 chk("t2_eq_kill", 32'(bus.kill), 1);
      tick(); clr();
      chk("t2_eq_exc",   32'(bus.exception), 1);
      chk("t2_eq_cause", 32'(bus.cause), 13);
      chk("t2_eq_epc",   bus.epc_out, 32'h100);
      tick(); tick();
      bus.status = 32'h1; bus.instr_valid = 1; bus.is_break = 1; bus.pc = 32'h104;
      #1 chk("t2_brk_kill", 32'(bus.kill), 0);
      tick(); clr();
      chk("t2_brk_exc",   32'(bus.exception), 0);
      chk("t2_brk_stall", 32'(bus.stall), 0);

      // 3: interrupt through synchronizer
      bus.status = 32'h11; bus.int_req = 4'b0100; bus.instr_valid = 1; bus.pc = 32'h40;
      tick();
      chk("t3_c1_exc", 32'(bus.exception), 0);
      chk("t3_c1_kill", 32'(bus.kill), 0);
      tick();
      chk("t3_c2_exc", 32'(bus.exception), 0);
      chk("t3_c2_kill", 32'(bus.kill), 1);
      tick(); clr(); bus.int_req = 0;
      chk("t3_exc",   32'(bus.exception), 1);
      chk("t3_cause", 32'(bus.cause), 0);
      chk("t3_epc",   bus.epc_out, 32'h40);
      tick(); tick();

      // 4: interrupt + syscall, then pending interrupt after settle
      bus.status = 32'h13; bus.int_req = 4'b0001;
      tick(); tick();
      bus.instr_valid = 1; bus.is_syscall = 1; bus.pc = 32'h200;
      #1 chk("t4_kill", 32'(bus.kill), 1);
      tick();
      chk("t4_exc",   32'(bus.exception), 1);
      chk("t4_cause", 32'(bus.cause), 8);
      chk("t4_epc",   bus.epc_out, 32'h200);
      bus.is_syscall = 0; bus.pc = 32'h204; bus.status = 32'h11;
      tick();
      chk("t4_set_kill", 32'(bus.kill), 0);
      tick();
      chk("t4_idle_kill", 32'(bus.kill), 1);
      tick(); clr(); bus.int_req = 0;
      chk("t4_exc2",   32'(bus.exception), 1);
      chk("t4_cause2", 32'(bus.cause), 0);
      chk("t4_epc2",   bus.epc_out, 32'h204);
      tick(); tick();

      // 5: eret
      bus.instr_valid = 1; bus.is_eret = 1; bus.epc_in = 32'h0040_0200; bus.pc = 32'h300;
      #1 chk("t5_kill", 32'(bus.kill), 0);
      tick(); clr();
      chk("t5_eret",  32'(bus.eret), 1);
      chk("t5_exc",   32'(bus.exception), 0);
      chk("t5_raddr", bus.redirect_addr, 32'h0040_0200);
      chk("t5_pcr",   32'(bus.pc_redirect), 1);
      chk("t5_epc_hold", bus.epc_out, 32'h204);
      tick();
      chk("t5_set_eret",  32'(bus.eret), 0);
      chk("t5_set_stall", 32'(bus.stall), 1);
      chk("t5_set_raddr", bus.redirect_addr, 0);
      tick();
      chk("t5_idle_stall", 32'(bus.stall), 0);

      // interrupt beats a coinciding eret
      bus.status = 32'h11; bus.int_req = 4'b1000;
      tick(); tick();
      bus.instr_valid = 1; bus.is_eret = 1; bus.pc = 32'h500;
      #1 chk("t5i_kill", 32'(bus.kill), 1);
      tick(); clr(); bus.int_req = 0;
      chk("t5i_exc",   32'(bus.exception), 1);
      chk("t5i_eret",  32'(bus.eret), 0);
      chk("t5i_cause", 32'(bus.cause), 0);
      chk("t5i_epc",   bus.epc_out, 32'h500);
      tick(); tick();

      // 6: reset during EXC, syscall during SETTLE ignored
      bus.status = 32'h3; bus.instr_valid = 1; bus.is_syscall = 1; bus.pc = 32'h0040_0100;
      tick(); clr();
      chk("t6_exc", 32'(bus.exception), 1);
      rst = 1;
      tick();
      rst = 0;
      chk("t6_rst_exc",   32'(bus.exception), 0);
      chk("t6_rst_stall", 32'(bus.stall), 0);
      chk("t6_rst_pcr",   32'(bus.pc_redirect), 0);
      chk("t6_rst_cause", 32'(bus.cause), 0);
      chk("t6_rst_epc",   bus.epc_out, 0);
      bus.instr_valid = 1; bus.is_syscall = 1; bus.pc = 32'h0040_0100;
      tick(); clr();
      chk("t6_exc2", 32'(bus.exception), 1);
      tick();
      bus.instr_valid = 1; bus.is_syscall = 1; bus.pc = 32'h600;
      #1 chk("t6_set_kill", 32'(bus.kill), 0);
      tick(); clr();
      chk("t6_idle_exc",   32'(bus.exception), 0);
      chk("t6_idle_stall", 32'(bus.stall), 0);
      chk("t6_idle_epc",   bus.epc_out, 32'h0040_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
